// File: rtl/proc_pkg.sv
// Shared definitions for the fetch/sequencing controller: opcodes,
// instruction field positions and the sequencer state encoding.
package proc_pkg;

  // Instruction field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Control-flow opcodes; everything else goes to execute
  localparam logic [5:0] OP_BEQ  = 6'b001000;
  localparam logic [5:0] OP_BNE  = 6'b001001;
  localparam logic [5:0] OP_BGT  = 6'b001010;
  localparam logic [5:0] OP_BGE  = 6'b001011;
  localparam logic [5:0] OP_BLT  = 6'b001100;
  localparam logic [5:0] OP_BLE  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b001110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    RESOLVE,
    ISSUE,
    HALT
  } seq_state_t;

  // Conditional branches occupy a contiguous opcode range
  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BLE);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: signed 32-bit compare of rd against rs,
// selected by opcode. Non-branch opcodes report not-taken.
module branch_cond
  import proc_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] rs_data_i,
  output logic        taken_o
);

  logic signed [31:0] rd_s;
  logic signed [31:0] rs_s;

  assign rd_s = rd_data_i;
  assign rs_s = rs_data_i;

  // Decode the comparison for the current opcode
  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OP_BEQ:  taken_o = (rd_s == rs_s);
      OP_BNE:  taken_o = (rd_s != rs_s);
      OP_BGT:  taken_o = (rd_s >  rs_s);
      OP_BGE:  taken_o = (rd_s >= rs_s);
      OP_BLT:  taken_o = (rd_s <  rs_s);
      OP_BLE:  taken_o = (rd_s <= rs_s);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/sequencing controller owning the PC. Fetches one instruction per
// trip, resolves branches and jumps locally, hands other instructions to
// execute over valid/ready, and stops on halt.
module branch_sequencer
  import proc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   imem_req,
  output logic [ADDRESS_WIDTH:0] imem_addr,
  input  logic                   imem_valid,
  input  logic [31:0]            imem_data,
  output logic [4:0]             rf_rd_addr,
  output logic [4:0]             rf_rs_addr,
  input  logic [31:0]            rf_rd_data,
  input  logic [31:0]            rf_rs_data,
  output logic                   issue_valid,
  output logic [31:0]            issue_instr,
  input  logic                   issue_ready,
  output logic [ADDRESS_WIDTH:0] pc,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   retired_count,
  output logic [CNT_WIDTH-1:0]   taken_count
);

  seq_state_t             state_q;
  logic [ADDRESS_WIDTH:0] pc_q;
  logic [31:0]            instr_q;
  logic                   imem_req_q;
  logic                   issue_valid_q;
  logic                   halted_q;
  logic [CNT_WIDTH-1:0]   retired_q;
  logic [CNT_WIDTH-1:0]   taken_q;

  logic [ADDRESS_WIDTH:0] pc_inc_d;
  logic [CNT_WIDTH-1:0]   retired_d;
  logic [CNT_WIDTH-1:0]   taken_d;
  logic [5:0]             opcode;
  logic [ADDRESS_WIDTH:0] target;
  logic                   br_taken;

  assign opcode    = instr_q[OPC_MSB:OPC_LSB];
  // Absolute target: only the low PC-width bits of the immediate matter
  assign target    = instr_q[ADDRESS_WIDTH:0];
  assign pc_inc_d  = pc_q + 1'b1;
  assign retired_d = retired_q + 1'b1;
  assign taken_d   = taken_q + 1'b1;

  // Register-file data arrives one cycle after the address, so the
  // condition is evaluated in RESOLVE, the cycle after DECODE.
  branch_cond u_cond (
    .opcode_i  (opcode),
    .rd_data_i (rf_rd_data),
    .rs_data_i (rf_rs_data),
    .taken_o   (br_taken)
  );

  // Sequencer FSM with registered handshake outputs, PC and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      issue_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
      taken_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_valid) begin
            instr_q    <= imem_data;
            imem_req_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          if (is_branch(opcode)) begin
            state_q <= RESOLVE;
          end else if (opcode == OP_J) begin
            pc_q       <= target;
            taken_q    <= taken_d;
            retired_q  <= retired_d;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end else if (opcode == OP_HALT) begin
            halted_q  <= 1'b1;
            retired_q <= retired_d;
            state_q   <= HALT;
          end else begin
            issue_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        RESOLVE: begin
          if (br_taken) begin
            pc_q    <= target;
            taken_q <= taken_d;
          end else begin
            pc_q <= pc_inc_d;
          end
          retired_q  <= retired_d;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        ISSUE: begin
          if (issue_ready) begin
            issue_valid_q <= 1'b0;
            pc_q          <= pc_inc_d;
            retired_q     <= retired_d;
            imem_req_q    <= 1'b1;
            state_q       <= FETCH;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc_q;
  assign rf_rd_addr    = instr_q[RD_MSB:RD_LSB];
  assign rf_rs_addr    = instr_q[RS_MSB:RS_LSB];
  assign issue_valid   = issue_valid_q;
  assign issue_instr   = issue_valid_q ? instr_q : 32'h0;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign retired_count = retired_q;
  assign taken_count   = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a zero/fixed-wait instruction
// memory model and an issue scoreboard checked at each transfer.
module tb_branch_sequencer;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [4:0]  rf_rd_addr;
  logic [4:0]  rf_rs_addr;
  logic [31:0] rf_rd_data = 32'h0;
  logic [31:0] rf_rs_data = 32'h0;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic        issue_ready = 1'b0;
  logic [5:0]  pc;
  logic        halted;
  logic [15:0] retired_count;
  logic [15:0] taken_count;

  logic [31:0] mem [0:63];
  int          req_cycles = 0;
  int          mem_delay = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  pc;
  } sb_t;
  sb_t exp_q[$];

  // Memory answers once the request has been up for more than mem_delay cycles
  assign imem_valid = imem_req && (req_cycles > mem_delay);
  assign imem_data  = mem[imem_addr];

  initial forever #5 clk = ~clk;

  branch_sequencer #(.ADDRESS_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rs_addr    (rf_rs_addr),
    .rf_rd_data    (rf_rd_data),
    .rf_rs_data    (rf_rs_data),
    .issue_valid   (issue_valid),
    .issue_instr   (issue_instr),
    .issue_ready   (issue_ready),
    .pc            (pc),
    .halted        (halted),
    .retired_count (retired_count),
    .taken_count   (taken_count)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score a transfer about to happen on this edge, then advance
  task automatic tick();
    sb_t e;
    if (!reset && issue_valid && issue_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_unexpected observed instr=%08h expected no transfer", issue_instr);
      end else begin
        e = exp_q.pop_front();
        $display("issue pc=%0d instr=%08h", pc, issue_instr);
        chk("sb_instr", issue_instr, e.instr);
        chk("sb_pc", 32'(pc), 32'(e.pc));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (imem_req) req_cycles++;
    else          req_cycles = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = mk(OP_HALT, 5'd0, 5'd0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    mem_delay = 0;
    tick();
    tick();
    reset = 1'b0;
    fill_mem();
  endtask

  task automatic check_zero(input string p);
    chk({p, "_imem_req"}, 32'(imem_req), 32'h0);
    chk({p, "_imem_addr"}, 32'(imem_addr), 32'h0);
    chk({p, "_rf_rd"}, 32'(rf_rd_addr), 32'h0);
    chk({p, "_rf_rs"}, 32'(rf_rs_addr), 32'h0);
    chk({p, "_issue_valid"}, 32'(issue_valid), 32'h0);
    chk({p, "_issue_instr"}, issue_instr, 32'h0);
    chk({p, "_pc"}, 32'(pc), 32'h0);
    chk({p, "_halted"}, 32'(halted), 32'h0);
    chk({p, "_retired"}, 32'(retired_count), 32'h0);
    chk({p, "_taken"}, 32'(taken_count), 32'h0);
  endtask

  // j 8, then the branch at pc 8; check the next fetch address
  task automatic run_branch(input string nm, input logic [5:0] op, input logic [31:0] rd,
                            input logic [31:0] rs, input logic [15:0] imm,
                            input logic [5:0] exp_addr, input int exp_tk);
    do_reset();
    mem[0] = mk(OP_J, 5'd0, 5'd0, 16'd8);
    mem[8] = mk(op, 5'd3, 5'd4, imm);
    rf_rd_data = rd;
    rf_rs_data = rs;
    start = 1'b1;
    repeat (6) tick();
    $display("branch %s rd=%08h rs=%08h next=%0d", nm, rd, rs, imem_addr);
    chk({nm, "_req"}, 32'(imem_req), 32'h1);
    chk({nm, "_addr"}, 32'(imem_addr), 32'(exp_addr));
    chk({nm, "_taken"}, 32'(taken_count), 32'(1 + exp_tk));
    chk({nm, "_retired"}, 32'(retired_count), 32'h2);
  endtask

  initial begin
    int cyc;
    int hi;
    fill_mem();

    // Reset state
    do_reset();
    check_zero("rst");

    // Three nops then halt
    for (int i = 0; i < 3; i++) begin
      mem[i] = mk(6'b000000, 5'(i), 5'(i + 1), 16'(16'h100 + i));
      exp_q.push_back('{instr: mem[i], pc: 6'(i)});
    end
    mem[3] = mk(OP_HALT, 5'd0, 5'd0, 16'h0);
    issue_ready = 1'b1;
    start = 1'b1;
    cyc = 0;
    while (!halted && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("nop_cycles", 32'(cyc), 32'd12);
    chk("nop_halted", 32'(halted), 32'h1);
    chk("nop_pc", 32'(pc), 32'd3);
    chk("nop_retired", 32'(retired_count), 32'd4);
    chk("nop_taken", 32'(taken_count), 32'd0);
    chk("nop_sb_left", 32'(exp_q.size()), 32'd0);

    // blt at pc 5, taken and not taken
    do_reset();
    mem[0] = mk(OP_J, 5'd0, 5'd0, 16'd5);
    mem[5] = mk(OP_BLT, 5'd1, 5'd2, 16'h0014);
    rf_rd_data = 32'hFFFF_FFFD;
    rf_rs_data = 32'd2;
    start = 1'b1;
    repeat (6) tick();
    chk("blt_t_addr", 32'(imem_addr), 32'd20);
    chk("blt_t_req", 32'(imem_req), 32'h1);
    chk("blt_t_taken", 32'(taken_count), 32'd2);
    chk("blt_t_rf_rd", 32'(rf_rd_addr), 32'd1);
    chk("blt_t_rf_rs", 32'(rf_rs_addr), 32'd2);
    do_reset();
    mem[0] = mk(OP_J, 5'd0, 5'd0, 16'd5);
    mem[5] = mk(OP_BLT, 5'd1, 5'd2, 16'h0014);
    rf_rd_data = 32'd2;
    rf_rs_data = 32'hFFFF_FFFD;
    start = 1'b1;
    repeat (6) tick();
    chk("blt_nt_addr", 32'(imem_addr), 32'd6);
    chk("blt_nt_taken", 32'(taken_count), 32'd1);

    // Each branch opcode, true and false
    run_branch("beq_t", OP_BEQ, 32'd5, 32'd5, 16'h0020, 6'd32, 1);
    run_branch("beq_f", OP_BEQ, 32'd5, 32'd6, 16'h0020, 6'd9, 0);
    run_branch("bne_t", OP_BNE, 32'd5, 32'd6, 16'h0011, 6'd17, 1);
    run_branch("bne_f", OP_BNE, 32'd7, 32'd7, 16'h0011, 6'd9, 0);
    run_branch("bgt_t", OP_BGT, 32'd1, 32'hFFFF_FFFF, 16'h0003, 6'd3, 1);
    run_branch("bgt_f", OP_BGT, 32'hFFFF_FFFF, 32'd1, 16'h0003, 6'd9, 0);
    run_branch("bgt_eq", OP_BGT, 32'd4, 32'd4, 16'h0003, 6'd9, 0);
    run_branch("bge_t", OP_BGE, 32'd7, 32'd7, 16'h0041, 6'd1, 1);
    run_branch("bge_f", OP_BGE, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 16'h0041, 6'd9, 0);
    run_branch("blt_sgn", OP_BLT, 32'h8000_0000, 32'h7FFF_FFFF, 16'h003F, 6'd63, 1);
    run_branch("blt_f", OP_BLT, 32'd3, 32'd3, 16'h003F, 6'd9, 0);
    run_branch("ble_self", OP_BLE, 32'd3, 32'd3, 16'h0008, 6'd8, 1);
    run_branch("ble_f", OP_BLE, 32'd4, 32'd3, 16'h0008, 6'd9, 0);

    // Issue stall at pc 63 and wrap to 0
    do_reset();
    mem[0]  = mk(OP_J, 5'd0, 5'd0, 16'd63);
    mem[63] = 32'h0123_4567;
    issue_ready = 1'b0;
    exp_q.push_back('{instr: 32'h0123_4567, pc: 6'd63});
    n_xfer = 0;
    start = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(issue_valid), 32'h1);
      chk("stall_instr", issue_instr, 32'h0123_4567);
      tick();
    end
    chk("stall_pc", 32'(pc), 32'd63);
    issue_ready = 1'b1;
    tick();
    chk("wrap_xfers", 32'(n_xfer), 32'd1);
    chk("wrap_valid", 32'(issue_valid), 32'h0);
    chk("wrap_req", 32'(imem_req), 32'h1);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_retired", 32'(retired_count), 32'd2);
    chk("wrap_sb_left", 32'(exp_q.size()), 32'd0);

    // Slow memory, then j 10
    do_reset();
    issue_ready = 1'b0;
    mem_delay = 5;
    mem[0] = mk(OP_J, 5'd0, 5'd0, 16'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    hi = 0;
    cyc = 0;
    while (imem_req && cyc < 20) begin
      hi++;
      chk("dly_no_issue", 32'(issue_valid), 32'h0);
      tick();
      cyc++;
    end
    chk("dly_req_cycles", 32'(hi), 32'd6);
    tick();
    chk("dly_addr", 32'(imem_addr), 32'd10);
    chk("dly_req", 32'(imem_req), 32'h1);
    chk("dly_retired", 32'(retired_count), 32'd1);
    chk("dly_taken", 32'(taken_count), 32'd1);
    chk("dly_no_issue_end", 32'(issue_valid), 32'h0);

    // Reset during ISSUE
    do_reset();
    mem[0] = mk(6'b000101, 5'd9, 5'd10, 16'h1234);
    issue_ready = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    chk("ri_valid", 32'(issue_valid), 32'h1);
    reset = 1'b1;
    tick();
    check_zero("ri");
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("ri_idle_req", 32'(imem_req), 32'h0);

    // Halt is terminal; start toggling ignored; reset clears
    mem[0] = mk(OP_HALT, 5'd0, 5'd0, 16'h0);
    start = 1'b1;
    repeat (3) tick();
    chk("h_halted", 32'(halted), 32'h1);
    chk("h_pc", 32'(pc), 32'd0);
    chk("h_retired", 32'(retired_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick();
      chk("h_toggle_req", 32'(imem_req), 32'h0);
      chk("h_toggle_halted", 32'(halted), 32'h1);
      chk("h_toggle_retired", 32'(retired_count), 32'd1);
    end
    reset = 1'b1;
    tick();
    check_zero("rh");
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
